// File: rtl/node_packet_sink.sv
// Ejection-side network interface: reassembles time-multiplexed VC flit streams into
// per-packet completion descriptors, delivered through a first-word-fall-through FIFO.
module node_packet_sink #(
    parameter int ID             = 0,
    parameter int N              = 9,
    parameter int VC             = 4,
    parameter int FlitsPerPacket = 16,
    parameter int DESC_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] flit_data,
    input  logic        flit_valid,
    output logic        flit_ready,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [13:0] desc_msg,
    output logic [7:0]  desc_src,
    output logic [2:0]  desc_vc,
    output logic [2:0]  desc_err,
    output logic [31:0] pkt_count,
    output logic [31:0] drop_count
);

    function automatic int isqrt(input int n);
        int r;
        r = 0;
        for (int i = 0; i <= n; i++) begin
            if (i * i <= n) r = i;
        end
        return r;
    endfunction

    localparam int DIM = isqrt(N);
    localparam int VCW = (VC > 1) ? $clog2(VC) : 1;
    localparam int CW  = $clog2(FlitsPerPacket) + 1;
    localparam int AW  = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int DW  = 28;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } vc_state_e;

    logic [VCW-1:0] slot_q;
    vc_state_e      state_q [VC];
    logic [13:0]    msg_q   [VC];
    logic [7:0]     src_q   [VC];
    logic [2:0]     err_q   [VC];
    logic [CW-1:0]  cnt_q   [VC];

    logic [DW-1:0]  fifo_q  [DESC_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic [31:0]    pkt_count_q, drop_count_q;

    logic           accept, pop, push, drop, upd;
    logic           is_head, is_tail, msg_mm, head_err0;
    logic [31:0]    dest_idx;
    logic [CW:0]    cnt_inc;
    vc_state_e      state_d;
    logic [13:0]    msg_d;
    logic [7:0]     src_d;
    logic [2:0]     err_d;
    logic [CW-1:0]  cnt_d;
    logic [DW-1:0]  push_data;

    assign flit_ready = (count_q != (AW+1)'(DESC_DEPTH));
    assign desc_valid = (count_q != '0);
    assign {desc_msg, desc_src, desc_vc, desc_err} = desc_valid ? fifo_q[rd_ptr_q] : '0;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

    always_comb begin
        accept    = flit_valid & flit_ready;
        pop       = desc_valid & desc_ready;
        is_head   = (flit_data[31:30] == 2'b01);
        is_tail   = (flit_data[31:30] == 2'b11);
        msg_mm    = (flit_data[29:16] != msg_q[slot_q]);
        dest_idx  = 32'(flit_data[3:0]) * 32'(DIM) + 32'(flit_data[7:4]);
        head_err0 = (dest_idx != 32'(ID));
        cnt_inc   = {1'b0, cnt_q[slot_q]} + 1'b1;

        push      = 1'b0;
        drop      = 1'b0;
        upd       = 1'b0;
        state_d   = state_q[slot_q];
        msg_d     = msg_q[slot_q];
        src_d     = src_q[slot_q];
        err_d     = err_q[slot_q];
        cnt_d     = cnt_q[slot_q];
        push_data = {msg_q[slot_q], src_q[slot_q], 3'(slot_q), err_q[slot_q]};

        if (accept) begin
            if (state_q[slot_q] == S_BODY && is_head) begin
                // new head preempts an open packet: flush it as a framing error
                push      = 1'b1;
                push_data = {msg_q[slot_q], src_q[slot_q], 3'(slot_q), err_q[slot_q] | 3'b100};
            end else if (state_q[slot_q] == S_BODY && is_tail) begin
                push      = 1'b1;
                push_data = {msg_q[slot_q], src_q[slot_q], 3'(slot_q),
                             err_q[slot_q] | {msg_mm, cnt_inc != (CW+1)'(FlitsPerPacket), 1'b0}};
                upd       = 1'b1;
                state_d   = S_IDLE;
            end else if (state_q[slot_q] == S_BODY) begin
                upd       = 1'b1;
                cnt_d     = cnt_inc[CW] ? '1 : cnt_inc[CW-1:0];
                err_d     = err_q[slot_q] | {msg_mm, cnt_inc >= (CW+1)'(FlitsPerPacket), 1'b0};
            end else if (!is_head) begin
                drop      = 1'b1;
            end

            if (is_head) begin
                upd       = 1'b1;
                state_d   = S_BODY;
                msg_d     = flit_data[29:16];
                src_d     = flit_data[15:8];
                err_d     = {2'b00, head_err0};
                cnt_d     = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            for (int i = 0; i < VC; i++) begin
                state_q[i] <= S_IDLE;
                msg_q[i]   <= '0;
                src_q[i]   <= '0;
                err_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            for (int i = 0; i < DESC_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            slot_q <= (slot_q == VCW'(VC - 1)) ? '0 : slot_q + 1'b1;
            if (upd) begin
                state_q[slot_q] <= state_d;
                msg_q[slot_q]   <= msg_d;
                src_q[slot_q]   <= src_d;
                err_q[slot_q]   <= err_d;
                cnt_q[slot_q]   <= cnt_d;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (push && pkt_count_q != '1) pkt_count_q <= pkt_count_q + 1'b1;
            if (drop && drop_count_q != '1) drop_count_q <= drop_count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_node_packet_sink.sv
// Bench for node_packet_sink: directed scenarios plus a random flit stream, checked
// against a packet-level model that judges each packet from its head and flit tally.
module tb_node_packet_sink;

    localparam int ID    = 4;
    localparam int N     = 9;
    localparam int VC    = 4;
    localparam int FPP   = 4;
    localparam int DEPTH = 4;
    localparam int DIM   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] flit_data = '0;
    logic        flit_valid = 1'b0;
    logic        flit_ready;
    logic        desc_valid;
    logic        desc_ready = 1'b0;
    logic [13:0] desc_msg;
    logic [7:0]  desc_src;
    logic [2:0]  desc_vc;
    logic [2:0]  desc_err;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;

    node_packet_sink #(
        .ID(ID), .N(N), .VC(VC), .FlitsPerPacket(FPP), .DESC_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .flit_data(flit_data), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_msg(desc_msg), .desc_src(desc_src), .desc_vc(desc_vc), .desc_err(desc_err),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] msg;
        logic [7:0]  src;
        logic [2:0]  vc;
        logic [2:0]  err;
    } desc_t;

    desc_t       exp_q[$];
    logic [31:0] m_head [VC];
    int          m_len  [VC];
    bit          m_mm   [VC];
    int          m_slot;
    logic [31:0] m_pkt, m_drop;
    int          checks = 0;
    int          errors = 0;
    bit          dr = 1'b0;

    // Judge a finished packet as a whole: destination from the head, length from the
    // flit tally, framing from any message-id mismatch or preemption by a new head.
    function automatic desc_t judge(input int vc, input bit preempted);
        desc_t d;
        logic [31:0] h;
        h     = m_head[vc];
        d.msg = h[29:16];
        d.src = h[15:8];
        d.vc  = 3'(vc);
        d.err[0] = ((int'(h[3:0]) * DIM + int'(h[7:4])) != ID);
        d.err[1] = preempted ? (m_len[vc] >= FPP) : (m_len[vc] != FPP);
        d.err[2] = preempted || m_mm[vc];
        return d;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < VC; i++) begin
            m_head[i] = '0;
            m_len[i]  = 0;
            m_mm[i]   = 1'b0;
        end
        m_slot = 0;
        m_pkt  = '0;
        m_drop = '0;
    endtask

    task automatic model_flit(input int vc, input logic [31:0] f);
        if (m_len[vc] == 0) begin
            if (f[31:30] == 2'b01) begin
                m_head[vc] = f; m_len[vc] = 1; m_mm[vc] = 1'b0;
            end else begin
                m_drop = m_drop + 1;
            end
        end else if (f[31:30] == 2'b01) begin
            exp_q.push_back(judge(vc, 1'b1));
            m_pkt = m_pkt + 1;
            m_head[vc] = f; m_len[vc] = 1; m_mm[vc] = 1'b0;
        end else begin
            m_len[vc] = m_len[vc] + 1;
            if (f[29:16] != m_head[vc][29:16]) m_mm[vc] = 1'b1;
            if (f[31:30] == 2'b11) begin
                exp_q.push_back(judge(vc, 1'b0));
                m_pkt = m_pkt + 1;
                m_len[vc] = 0;
            end
        end
    endtask

    // One clock: compare DUT against the model at the negedge, drive, advance the model.
    task automatic step(input bit v, input logic [31:0] d);
        bit acc, pp;
        int sl;
        checks++;
        if (flit_ready !== (exp_q.size() != DEPTH)) begin
            errors++; $display("FAIL sb_ready: got %b want %b", flit_ready, exp_q.size() != DEPTH);
        end
        checks++;
        if (desc_valid !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL sb_valid: got %b want %b", desc_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if ({desc_msg, desc_src, desc_vc, desc_err} !== exp_q[0]) begin
                errors++;
                $display("FAIL sb_desc: got msg=%h src=%h vc=%0d err=%b want msg=%h src=%h vc=%0d err=%b",
                         desc_msg, desc_src, desc_vc, desc_err,
                         exp_q[0].msg, exp_q[0].src, exp_q[0].vc, exp_q[0].err);
            end
        end
        checks++;
        if (pkt_count !== m_pkt) begin
            errors++; $display("FAIL sb_pkt_count: got %0d want %0d", pkt_count, m_pkt);
        end
        checks++;
        if (drop_count !== m_drop) begin
            errors++; $display("FAIL sb_drop_count: got %0d want %0d", drop_count, m_drop);
        end
        flit_valid = v;
        flit_data  = d;
        desc_ready = dr;
        acc = v && (exp_q.size() != DEPTH);
        pp  = dr && (exp_q.size() != 0);
        sl  = m_slot;
        @(posedge clk);
        if (pp) void'(exp_q.pop_front());
        if (acc) model_flit(sl, d);
        m_slot = (m_slot + 1) % VC;
        @(negedge clk);
        flit_valid = 1'b0;
    endtask

    task automatic send(input int vc, input logic [31:0] d);
        int guard;
        guard = 0;
        while (!(m_slot == vc && exp_q.size() != DEPTH) && guard < 64) begin
            step(1'b0, '0);
            guard++;
        end
        if (guard >= 64) begin
            checks++; errors++;
            $display("FAIL send_timeout: vc=%0d flit=%h never accepted", vc, d);
        end else begin
            step(1'b1, d);
        end
    endtask

    task automatic drain();
        dr = 1'b1;
        repeat (DEPTH + 2) step(1'b0, '0);
        dr = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (flit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", flit_ready); end
        checks++;
        if (desc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", desc_valid); end
        checks++;
        if ({desc_msg, desc_src, desc_vc, desc_err} !== 28'd0) begin
            errors++; $display("FAIL reset_fields: got %h want 0", {desc_msg, desc_src, desc_vc, desc_err});
        end
        checks++;
        if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts: got pkt=%0d drop=%0d want 0/0", pkt_count, drop_count);
        end
    endtask

    task automatic test_clean();
        dr = 1'b0;
        send(0, 32'h40050211);
        send(0, 32'h80050000);
        send(0, 32'h80050000);
        checks++;
        if (desc_valid !== 1'b0) begin errors++; $display("FAIL clean_early: got %b want 0", desc_valid); end
        send(0, 32'hC0050000);
        checks++;
        if ({desc_valid, desc_msg, desc_src, desc_vc, desc_err} !== {1'b1, 14'd5, 8'h02, 3'd0, 3'b000}) begin
            errors++;
            $display("FAIL clean_desc: got v=%b msg=%h src=%h vc=%0d err=%b want v=1 msg=5 src=02 vc=0 err=000",
                     desc_valid, desc_msg, desc_src, desc_vc, desc_err);
        end
        checks++;
        if (pkt_count !== 32'd1) begin errors++; $display("FAIL clean_pkt_count: got %0d want 1", pkt_count); end
        drain();
    endtask

    task automatic test_interleave();
        dr = 1'b0;
        send(1, 32'h40010311); send(3, 32'h40020511);
        send(1, 32'h80010000); send(3, 32'h80020000);
        send(1, 32'h80010000); send(3, 32'h80020000);
        send(1, 32'hC0010000); send(3, 32'hC0020000);
        checks++;
        if ({desc_msg, desc_vc, desc_err} !== {14'd1, 3'd1, 3'b000}) begin
            errors++; $display("FAIL ilv_first: got msg=%h vc=%0d err=%b want 1/1/000", desc_msg, desc_vc, desc_err);
        end
        dr = 1'b1; step(1'b0, '0); dr = 1'b0;
        checks++;
        if ({desc_msg, desc_vc, desc_err} !== {14'd2, 3'd3, 3'b000}) begin
            errors++; $display("FAIL ilv_second: got msg=%h vc=%0d err=%b want 2/3/000", desc_msg, desc_vc, desc_err);
        end
        drain();
    endtask

    task automatic test_errors();
        desc_t want [4];
        dr = 1'b0;
        send(2, 32'h40070212); send(2, 32'h80070000); send(2, 32'h80070000); send(2, 32'hC0070000);
        send(1, 32'h40080311); send(1, 32'h80080000); send(1, 32'hC0080000);
        send(0, 32'h40090411); send(0, 32'h80090000);
        send(0, 32'h400A0511); send(0, 32'h800A0000); send(0, 32'h800A0000); send(0, 32'hC00A0000);
        want[0] = '{msg: 14'd7,  src: 8'h02, vc: 3'd2, err: 3'b001};
        want[1] = '{msg: 14'd8,  src: 8'h03, vc: 3'd1, err: 3'b010};
        want[2] = '{msg: 14'd9,  src: 8'h04, vc: 3'd0, err: 3'b100};
        want[3] = '{msg: 14'd10, src: 8'h05, vc: 3'd0, err: 3'b000};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({desc_valid, desc_msg, desc_src, desc_vc, desc_err} !== {1'b1, want[i]}) begin
                errors++;
                $display("FAIL err_desc%0d: got v=%b msg=%h src=%h vc=%0d err=%b want msg=%h src=%h vc=%0d err=%b",
                         i, desc_valid, desc_msg, desc_src, desc_vc, desc_err,
                         want[i].msg, want[i].src, want[i].vc, want[i].err);
            end
            dr = 1'b1; step(1'b0, '0); dr = 1'b0;
        end
    endtask

    task automatic test_orphan();
        send(2, 32'hC0090000);
        checks++;
        if (drop_count !== 32'd1 || desc_valid !== 1'b0) begin
            errors++; $display("FAIL orphan: got drop=%0d valid=%b want 1/0", drop_count, desc_valid);
        end
        repeat (4) step(1'b0, '0);
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        dr = 1'b0;
        base = m_pkt;
        for (int p = 0; p < 4; p++) begin
            send(0, {2'b01, 14'(32 + p), 8'h02, 8'h11});
            send(0, {2'b10, 14'(32 + p), 16'h0});
            send(0, {2'b10, 14'(32 + p), 16'h0});
            send(0, {2'b11, 14'(32 + p), 16'h0});
        end
        checks++;
        if (flit_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got ready=%b want 0", flit_ready); end
        for (int i = 0; i < 8; i++) step(m_slot == 0, 32'h40300211);
        checks++;
        if (pkt_count !== base + 32'd4 || drop_count !== m_drop) begin
            errors++; $display("FAIL bp_hold: got pkt=%0d drop=%0d want %0d/%0d", pkt_count, drop_count, base + 4, m_drop);
        end
        dr = 1'b1; step(1'b0, '0); dr = 1'b0;
        checks++;
        if (flit_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ready=%b want 1", flit_ready); end
        send(0, 32'h40300211); send(0, 32'h80300000); send(0, 32'h80300000); send(0, 32'hC0300000);
        checks++;
        if (pkt_count !== base + 32'd5 || flit_ready !== 1'b0) begin
            errors++; $display("FAIL bp_fifth: got pkt=%0d ready=%b want %0d/0", pkt_count, flit_ready, base + 5);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        dr = 1'b0;
        send(0, 32'h40400211);
        send(0, 32'h80400000);
        rst = 1'b1;
        #1;
        checks++;
        if ({flit_ready, desc_valid, pkt_count, drop_count} !== {1'b1, 1'b0, 32'd0, 32'd0}
            || {desc_msg, desc_src, desc_vc, desc_err} !== 28'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: got ready=%b valid=%b pkt=%0d drop=%0d fields=%h want 1/0/0/0/0",
                     flit_ready, desc_valid, pkt_count, drop_count, {desc_msg, desc_src, desc_vc, desc_err});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(0, 32'h80400000);
        checks++;
        if (drop_count !== 32'd1) begin errors++; $display("FAIL rst_mid_drop: got %0d want 1", drop_count); end
        send(0, 32'h40410211); send(0, 32'h80410000); send(0, 32'h80410000); send(0, 32'hC0410000);
        checks++;
        if ({desc_valid, desc_msg, desc_vc, desc_err, pkt_count} !== {1'b1, 14'h41, 3'd0, 3'b000, 32'd1}) begin
            errors++;
            $display("FAIL rst_mid_pkt: got v=%b msg=%h vc=%0d err=%b pkt=%0d want 1/41/0/000/1",
                     desc_valid, desc_msg, desc_vc, desc_err, pkt_count);
        end
        drain();
    endtask

    task automatic test_random();
        logic [1:0]  typ;
        logic [13:0] msg;
        logic [3:0]  row, col;
        int r;
        for (int c = 0; c < 2000; c++) begin
            dr  = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 99);
            typ = (r < 25) ? 2'b01 : (r < 65) ? 2'b10 : (r < 95) ? 2'b11 : 2'b00;
            msg = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'(m_slot);
            if ($urandom_range(0, 1) == 0) begin
                row = 4'd1; col = 4'd1;
            end else begin
                row = 4'($urandom); col = 4'($urandom);
            end
            step($urandom_range(0, 2) != 0, {typ, msg, 8'($urandom), col, row});
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_clean();
        test_interleave();
        test_errors();
        test_orphan();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
